// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the pipeline hazard controller.
// Optional perf counters are enabled with macro HAZARD_PERF_CNT_EN.
package hazard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 32;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // True when a source register is actually read and matches a non-zero destination.
    function automatic logic f_src_hit(
        input logic                 used,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rd
    );
        return used && (rd != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: enable-gated event counter with async clear that
// sticks at all-ones instead of wrapping.
module hazard_sat_counter
    import hazard_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, holding at full scale.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect control for a 5-stage pipeline.
// Outputs are combinational from state and inputs (zero-cycle latency).
// Define HAZARD_PERF_CNT_EN to add load-use, mem-stall and flush counters.
//
// state       | meaning
// ST_RUN      | pipeline advancing normally
// ST_MEM_WAIT | previous cycle was held by a busy data memory
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_idex_mem_read,
    input  logic [REG_IDX_W-1:0] i_idex_rd,
    input  logic [REG_IDX_W-1:0] i_ifid_rs1,
    input  logic [REG_IDX_W-1:0] i_ifid_rs2,
    input  logic                 i_ifid_rs1_used,
    input  logic                 i_ifid_rs2_used,
    input  logic                 i_ex_mispredict,
    input  logic                 i_mem_busy,
    output logic                 o_pc_en,
    output logic                 o_ifid_en,
    output logic                 o_idex_en,
    output logic                 o_exmem_en,
    output logic                 o_ifid_flush,
    output logic                 o_idex_flush,
    output logic                 o_redirect
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     o_cnt_load_use,
    output logic [CNT_W-1:0]     o_cnt_mem_stall,
    output logic [CNT_W-1:0]     o_cnt_flush
`endif
);

    hz_state_t r_state;
    logic      r_redirect_pend;

    logic w_load_use;
    logic w_eff_mispredict;
    logic w_do_flush;
    logic w_do_bubble;

    assign w_load_use = i_idex_mem_read &&
                        (f_src_hit(i_ifid_rs1_used, i_ifid_rs1, i_idex_rd) ||
                         f_src_hit(i_ifid_rs2_used, i_ifid_rs2, i_idex_rd));

    // A mispredict seen during a memory hold is remembered until it can be applied.
    assign w_eff_mispredict = i_ex_mispredict || r_redirect_pend;

    assign w_do_flush  = !i_rst && !i_mem_busy && w_eff_mispredict;
    assign w_do_bubble = !i_rst && !i_mem_busy && !w_eff_mispredict && w_load_use;

    // Priority decode: reset > mem_busy > mispredict > load-use > normal.
    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_idex_en    = 1'b0;
        o_exmem_en   = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_redirect   = 1'b0;
        if (i_rst || i_mem_busy) begin
            // everything frozen
        end else if (w_eff_mispredict) begin
            // IF/ID is enabled so the flush actually loads the bubble
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_idex_en    = 1'b1;
            o_exmem_en   = 1'b1;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_redirect   = 1'b1;
        end else if (w_load_use) begin
            o_idex_en    = 1'b1;
            o_exmem_en   = 1'b1;
            o_idex_flush = 1'b1;
        end else begin
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_idex_en    = 1'b1;
            o_exmem_en   = 1'b1;
        end
    end

    // State and pending-redirect update; a non-busy cycle always returns to RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_RUN;
            r_redirect_pend <= 1'b0;
        end else begin
            r_redirect_pend <= i_mem_busy ? w_eff_mispredict : 1'b0;
            case (r_state)
                ST_RUN:      r_state <= i_mem_busy ? ST_MEM_WAIT : ST_RUN;
                ST_MEM_WAIT: r_state <= i_mem_busy ? ST_MEM_WAIT : ST_RUN;
                default:     r_state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_ev;
    assign w_stall_ev = !i_rst && i_mem_busy;

    hazard_sat_counter u_cnt_load_use (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_en  (w_do_bubble),
        .o_cnt (o_cnt_load_use)
    );

    hazard_sat_counter u_cnt_mem_stall (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_en  (w_stall_ev),
        .o_cnt (o_cnt_mem_stall)
    );

    hazard_sat_counter u_cnt_flush (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_en  (w_do_flush),
        .o_cnt (o_cnt_flush)
    );
`else
    logic w_unused;
    assign w_unused = w_do_flush ^ w_do_bubble;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expected outputs.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       idex_mem_read;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_mispredict;
    logic       mem_busy;
    logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, redirect;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_load_use, cnt_mem_stall, cnt_flush;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .i_ifid_rs1      (ifid_rs1),
        .i_ifid_rs2      (ifid_rs2),
        .i_ifid_rs1_used (rs1_used),
        .i_ifid_rs2_used (rs2_used),
        .i_ex_mispredict (ex_mispredict),
        .i_mem_busy      (mem_busy),
        .o_pc_en         (pc_en),
        .o_ifid_en       (ifid_en),
        .o_idex_en       (idex_en),
        .o_exmem_en      (exmem_en),
        .o_ifid_flush    (ifid_flush),
        .o_idex_flush    (idex_flush),
        .o_redirect      (redirect)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_cnt_load_use  (cnt_load_use),
        .o_cnt_mem_stall (cnt_mem_stall),
        .o_cnt_flush     (cnt_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, redirect}
    localparam logic [6:0] O_NORM   = 7'b1111_000;
    localparam logic [6:0] O_ZERO   = 7'b0000_000;
    localparam logic [6:0] O_BUBBLE = 7'b0011_010;
    // mispredict view without ifid_en: {pc, idex, exmem, ifid_fl, idex_fl, redirect}
    localparam logic [5:0] M_FLUSH  = 6'b111_111;
    localparam logic [5:0] M_NORM   = 6'b111_000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, redirect};
    endfunction

    function automatic logic [5:0] mis_outs();
        return {pc_en, idex_en, exmem_en, ifid_flush, idex_flush, redirect};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic mis, input logic busy);
        idex_mem_read = mr;  idex_rd  = rd;
        ifid_rs1      = r1;  rs1_used = u1;
        ifid_rs2      = r2;  rs2_used = u2;
        ex_mispredict = mis; mem_busy = busy;
    endtask

    // advance one clock and land 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        check("reset_outs_zero", {25'd0, outs()}, {25'd0, O_ZERO});
`ifdef HAZARD_PERF_CNT_EN
        check("reset_cnt_lu", cnt_load_use, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
        #1 check("normal_after_reset", {25'd0, outs()}, {25'd0, O_NORM});

        // load x5 followed by consumer of x5 in rs1
        next_cycle();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        #1 check("load_use_rs1_bubble", {25'd0, outs()}, {25'd0, O_BUBBLE});
        next_cycle();
        drive(1'b0, 5'd0, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        #1 check("after_bubble_normal", {25'd0, outs()}, {25'd0, O_NORM});
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_load_use_1", cnt_load_use, 32'd1);
`endif

        // hazard through rs2
        next_cycle();
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        #1 check("load_use_rs2_bubble", {25'd0, outs()}, {25'd0, O_BUBBLE});
        // rs2 matches but is not read -> no hazard
        next_cycle();
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        #1 check("rs2_unused_no_stall", {25'd0, outs()}, {25'd0, O_NORM});
        // load to x0 never hazards
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("load_x0_no_stall", {25'd0, outs()}, {25'd0, O_NORM});
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_load_use_2", cnt_load_use, 32'd2);
`endif

        // memory busy for three cycles
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
            #1 check($sformatf("mem_busy_c%0d", i), {25'd0, outs()}, {25'd0, O_ZERO});
        end
        next_cycle();
        idle();
        #1 check("mem_busy_release_normal", {25'd0, outs()}, {25'd0, O_NORM});
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_mem_stall_3", cnt_mem_stall, 32'd3);
`endif

        // mispredict pulse in cycle 2 of a 3-cycle busy window
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, (i == 1), 1'b1);
            #1 check($sformatf("busy_mis_c%0d", i), {25'd0, outs()}, {25'd0, O_ZERO});
        end
        next_cycle();
        idle();
        #1 check("pending_redirect_applied", {26'd0, mis_outs()}, {26'd0, M_FLUSH});
        next_cycle();
        #1 check("pending_cleared", {25'd0, outs()}, {25'd0, O_NORM});
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_flush_1", cnt_flush, 32'd1);
        check("cnt_mem_stall_6", cnt_mem_stall, 32'd6);
`endif

        // mispredict and load-use together: mispredict wins
        next_cycle();
        drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        #1 check("mis_beats_load_use", {26'd0, mis_outs()}, {26'd0, M_FLUSH});
        next_cycle();
        idle();
        #1 check("after_mis_normal", {26'd0, mis_outs()}, {26'd0, M_NORM});
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_load_use_unchanged", cnt_load_use, 32'd2);
        check("cnt_flush_2", cnt_flush, 32'd2);
`endif

        // reset while a redirect is pending in MEM_WAIT
        next_cycle();
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
        next_cycle();
        idle();
        #1 check("pend_redirect_visible", {25'd0, outs()}, {25'd0, O_BUBBLE | 7'b1100_101});
        #1 rst = 1'b1;
        #1 check("async_reset_outs_zero", {25'd0, outs()}, {25'd0, O_ZERO});
`ifdef HAZARD_PERF_CNT_EN
        check("async_reset_cnt_flush", cnt_flush, 32'd0);
        check("async_reset_cnt_stall", cnt_mem_stall, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
        #1 check("post_reset_no_redirect", {25'd0, outs()}, {25'd0, O_NORM});
        next_cycle();
        #1 check("post_reset_steady", {25'd0, outs()}, {25'd0, O_NORM});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
